div_seq: RTL

Sequential restoring divider: the inverse companion to the shift-add multiplier datapath. Divides a 2N-bit dividend by an N-bit divisor, producing a 2N-bit quotient and N-bit remainder, one quotient bit per clock. It uses the same start/done handshake as the multiplier, so control FSMs and benches can drive either unit interchangeably, for example to recover one operand from a product.

---
 rtl/div_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock,
// start/done handshake. Optional macro DIV_ZERO_DETECT_EN short-circuits B=0 straight to DONE.
module div_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] quot,
    output logic [N-1:0]   rem,
    output logic           done,
    output logic           div_by_zero
);

    localparam int CW = $clog2(2*N) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(2*N-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [2*N-1:0]  dvd_reg;
    logic [N-1:0]    dsr_reg;
    logic [N:0]      r_reg;
    logic [2*N-1:0]  q_reg;
    logic [CW-1:0]   cnt_reg;
    logic [2*N-1:0]  quot_reg;
    logic [N-1:0]    rem_reg;

    logic [N:0]      r_shift;
    logic            r_ge;
    logic [N:0]      r_new;
    logic [2*N-1:0]  q_new;
    logic            last_iter;
    logic            zero_load;

    // One restoring step: bring in the next dividend bit, subtract when it fits.
    assign r_shift   = {r_reg[N-1:0], dvd_reg[2*N-1]};
    assign r_ge      = (r_shift >= {1'b0, dsr_reg});
    assign r_new     = r_ge ? (r_shift - {1'b0, dsr_reg}) : r_shift;
    assign q_new     = {q_reg[2*N-2:0], r_ge};
    assign last_iter = (cnt_reg == LAST_ITER);

`ifdef DIV_ZERO_DETECT_EN
    logic dz_reg;
    assign zero_load   = (B == '0);
    assign div_by_zero = dz_reg;
`else
    assign zero_load   = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = zero_load ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd_reg  <= '0;
            dsr_reg  <= '0;
            r_reg    <= '0;
            q_reg    <= '0;
            cnt_reg  <= '0;
            quot_reg <= '0;
            rem_reg  <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        dvd_reg  <= A;
                        dsr_reg  <= B;
                        r_reg    <= '0;
                        q_reg    <= '0;
                        cnt_reg  <= '0;
                        quot_reg <= '0;
                        rem_reg  <= '0;
`ifdef DIV_ZERO_DETECT_EN
                        dz_reg   <= 1'b0;
                        if (zero_load) begin
                            quot_reg <= '1;
                            rem_reg  <= A[N-1:0];
                            dz_reg   <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
                    dvd_reg <= {dvd_reg[2*N-2:0], 1'b0};
                    r_reg   <= r_new;
                    q_reg   <= q_new;
                    cnt_reg <= cnt_reg + CW'(1);
                    // Publish on the final step so results appear together with done.
                    if (last_iter) begin
                        quot_reg <= q_new;
                        rem_reg  <= r_new[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign quot = quot_reg;
    assign rem  = rem_reg;
    assign done = (state_reg == DONE);

endmodule
